// File: rtl/seven_seg_reader_if.sv
// Beat-in / result-out bundle for the seven-segment frame reader.
// The DUT takes the slave view and the producer/consumer takes the master view.
interface seven_seg_reader_if;
  logic [6:0]  i_seg;
  logic        i_seg_valid;
  logic        i_seg_last;
  logic        o_seg_ready;
  logic [13:0] o_value;
  logic [2:0]  o_ndigits;
  logic        o_err;
  logic        o_valid;
  logic        i_ready;

  modport slave (
    input  i_seg, i_seg_valid, i_seg_last, i_ready,
    output o_seg_ready, o_value, o_ndigits, o_err, o_valid
  );

  modport master (
    output i_seg, i_seg_valid, i_seg_last, i_ready,
    input  o_seg_ready, o_value, o_ndigits, o_err, o_valid
  );
endinterface

// File: rtl/seven_seg_reader.sv
// Decodes a frame of active-low seven-segment digit beats (MS digit first) into
// a binary value, flagging invalid patterns and frames longer than MAX_DIGITS.
module seven_seg_reader #(
  parameter int MAX_DIGITS = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  seven_seg_reader_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  logic [1:0]  state_q, state_d;
  logic [13:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [3:0]  digit;
  logic        digit_ok;
  logic        accept;
  logic        beat_ok;
  logic [2:0]  cnt_inc;

  // Pattern table is bit6..bit0, segments lit when low.
  always_comb begin
    digit    = 4'd0;
    digit_ok = 1'b1;
    case (bus.i_seg)
      7'b1000000: digit = 4'd0;
      7'b1111001: digit = 4'd1;
      7'b0100100: digit = 4'd2;
      7'b0110000: digit = 4'd3;
      7'b0011001: digit = 4'd4;
      7'b0010010: digit = 4'd5;
      7'b0000010: digit = 4'd6;
      7'b1011000: digit = 4'd7;
      7'b1111000: digit = 4'd7;
      7'b0000000: digit = 4'd8;
      7'b0010000: digit = 4'd9;
      default:    digit_ok = 1'b0;
    endcase
  end

  assign accept  = bus.i_seg_valid && (state_q != HOLD);
  assign cnt_inc = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;
  assign beat_ok = digit_ok && (cnt_q < MAX_CNT);

  // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (beat_ok) begin
            acc_d   = acc_q * 14'd10 + {10'd0, digit};
            state_d = bus.i_seg_last ? HOLD : ACCUM;
          end else begin
            err_d   = 1'b1;
            acc_d   = '0;
            state_d = bus.i_seg_last ? HOLD : DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (bus.i_seg_last) state_d = HOLD;
        end
      end
      HOLD: begin
        // Clearing on exit is what makes IDLE start from a zero accumulator.
        if (bus.i_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous and checked before anything else, so it wins over beats and i_ready.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_seg_ready = (state_q != HOLD);
  assign bus.o_valid     = (state_q == HOLD);
  assign bus.o_value     = acc_q;
  assign bus.o_ndigits   = cnt_q;
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed self-checking bench for seven_seg_reader (MAX_DIGITS = 4).
module tb_seven_seg_reader;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S6   = 7'b0000010;
  localparam logic [6:0] S7A  = 7'b1011000;
  localparam logic [6:0] S7B  = 7'b1111000;
  localparam logic [6:0] S8   = 7'b0000000;
  localparam logic [6:0] S9   = 7'b0010000;
  localparam logic [6:0] SBAD = 7'b1111111;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  seven_seg_reader_if bus ();

  seven_seg_reader #(.MAX_DIGITS(4)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one beat at the falling edge; it is sampled at the next rising edge.
  task automatic send_beat(input logic [6:0] seg, input logic last);
    @(negedge i_clk);
    bus.i_seg_valid = 1'b1;
    bus.i_seg       = seg;
    bus.i_seg_last  = last;
  endtask

  // One cycle after the last beat: check the held result, then release it.
  task automatic finish_frame(input string tag, input logic [13:0] value,
                              input logic [2:0] nd, input logic err);
    @(negedge i_clk);
    bus.i_seg_valid = 1'b0;
    check({tag, "_valid"},   32'(bus.o_valid),     32'd1);
    check({tag, "_ready"},   32'(bus.o_seg_ready), 32'd0);
    check({tag, "_value"},   32'(bus.o_value),     32'(value));
    check({tag, "_ndigits"}, 32'(bus.o_ndigits),   32'(nd));
    check({tag, "_err"},     32'(bus.o_err),       32'(err));
    bus.i_ready = 1'b1;
    @(negedge i_clk);
    bus.i_ready = 1'b0;
    check({tag, "_idle_valid"}, 32'(bus.o_valid),     32'd0);
    check({tag, "_idle_ready"}, 32'(bus.o_seg_ready), 32'd1);
    check({tag, "_idle_value"}, 32'(bus.o_value),     32'd0);
  endtask

  initial begin
    bus.i_seg       = '0;
    bus.i_seg_valid = 1'b0;
    bus.i_seg_last  = 1'b0;
    bus.i_ready     = 1'b0;

    // Reset state
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    check("rst_valid",   32'(bus.o_valid),     32'd0);
    check("rst_ready",   32'(bus.o_seg_ready), 32'd1);
    check("rst_value",   32'(bus.o_value),     32'd0);
    check("rst_ndigits", 32'(bus.o_ndigits),   32'd0);
    check("rst_err",     32'(bus.o_err),       32'd0);

    // 3,1,0,2 -> 3102; no o_valid before the last beat
    send_beat(S3, 1'b0);
    send_beat(S1, 1'b0);
    send_beat(S0, 1'b0);
    check("f3102_pre_valid", 32'(bus.o_valid), 32'd0);
    send_beat(S2, 1'b1);
    finish_frame("f3102", 14'd3102, 3'd4, 1'b0);

    // Single digit, then both spellings of 7
    send_beat(S9, 1'b1);
    finish_frame("f9", 14'd9, 3'd1, 1'b0);
    send_beat(S7A, 1'b0);
    send_beat(S7B, 1'b1);
    finish_frame("f77", 14'd77, 3'd2, 1'b0);

    // Invalid pattern mid-frame -> drain, error
    send_beat(S8, 1'b0);
    send_beat(SBAD, 1'b0);
    @(negedge i_clk);
    bus.i_seg_valid = 1'b0;
    check("drain_ready", 32'(bus.o_seg_ready), 32'd1);
    check("drain_valid", 32'(bus.o_valid),     32'd0);
    send_beat(S5, 1'b1);
    finish_frame("fbad", 14'd0, 3'd3, 1'b1);

    // Invalid single last beat
    send_beat(SBAD, 1'b1);
    finish_frame("fbad1", 14'd0, 3'd1, 1'b1);

    // Overflow: five 9s, then exactly four 9s
    for (int i = 0; i < 5; i++) send_beat(S9, (i == 4));
    finish_frame("f5x9", 14'd0, 3'd5, 1'b1);
    for (int i = 0; i < 4; i++) send_beat(S9, (i == 3));
    finish_frame("f9999", 14'd9999, 3'd4, 1'b0);

    // Digit count saturates at 7 while draining
    for (int i = 0; i < 9; i++) send_beat(S1, (i == 8));
    finish_frame("fsat", 14'd0, 3'd7, 1'b1);

    // Backpressure: hold for 10 cycles with beats offered
    send_beat(S4, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      bus.i_seg_valid = 1'b1;
      bus.i_seg       = S1;
      bus.i_seg_last  = i[0];
      check("hold_ready",   32'(bus.o_seg_ready), 32'd0);
      check("hold_valid",   32'(bus.o_valid),     32'd1);
      check("hold_value",   32'(bus.o_value),     32'd4);
      check("hold_ndigits", 32'(bus.o_ndigits),   32'd1);
    end
    @(negedge i_clk);
    bus.i_seg_valid = 1'b0;
    bus.i_ready     = 1'b1;
    @(negedge i_clk);
    bus.i_ready = 1'b0;
    check("hold_rel_valid", 32'(bus.o_valid),     32'd0);
    check("hold_rel_ready", 32'(bus.o_seg_ready), 32'd1);
    send_beat(S6, 1'b0);
    send_beat(S5, 1'b1);
    finish_frame("f65", 14'd65, 3'd2, 1'b0);

    // Reset mid-frame, with a simultaneous last beat offered
    send_beat(S4, 1'b0);
    send_beat(S2, 1'b0);
    @(negedge i_clk);
    check("prerst_valid", 32'(bus.o_valid), 32'd0);
    i_rst           = 1'b1;
    bus.i_seg_valid = 1'b1;
    bus.i_seg       = S9;
    bus.i_seg_last  = 1'b1;
    @(negedge i_clk);
    i_rst           = 1'b0;
    bus.i_seg_valid = 1'b0;
    check("midrst_valid",   32'(bus.o_valid),     32'd0);
    check("midrst_ready",   32'(bus.o_seg_ready), 32'd1);
    check("midrst_value",   32'(bus.o_value),     32'd0);
    check("midrst_ndigits", 32'(bus.o_ndigits),   32'd0);
    send_beat(S4, 1'b1);
    finish_frame("fpostrst", 14'd4, 3'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
